// File: rtl/left_shift_seq.sv
// ---------------------------------------------------------------------------
// left_shift_seq
//
// Purpose:
//   Sequential front-end for a 4-bit combinational left_shift stage.
//   That stage shifts by 0-3 positions per pass. This block accepts one
//   request over a valid/ready handshake. It then splits the total shift
//   amount into passes of at most 3 and drives the stage once per cycle,
//   registering each partial result. When all passes are done it presents:
//     - the final value,
//     - the carry of the last pass,
//     - a sticky overflow flag, which is set if any 1-bit was lost.
//
// Parameters:
//   AMT_W      width of req_amt; maximum total shift is 2^AMT_W-1
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   req_valid  request present
//   req_ready  block can accept a request (IDLE only, low during reset)
//   req_data   4-bit operand
//   req_amt    total left-shift amount
//   sh_in      operand for the external stage (current partial result)
//   sh_k       shift amount for this pass (0 outside SHIFT)
//   sh_out     shifted value returned by the external stage
//   sh_carry   last bit shifted out by the external stage this pass
//   rsp_valid  result present
//   rsp_ready  consumer accepts result
//   rsp_data   final shifted value
//   rsp_carry  carry of the final pass (0 when the amount was 0)
//   rsp_ovf    1 if any 1-bit was shifted out across all passes
//   busy       high whenever the block is not IDLE
// ---------------------------------------------------------------------------
module left_shift_seq #(
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_data,
  input  logic [AMT_W-1:0] req_amt,
  output logic [3:0]       sh_in,
  output logic [1:0]       sh_k,
  input  logic [3:0]       sh_out,
  input  logic             sh_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_data,
  output logic             rsp_carry,
  output logic             rsp_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;

  logic [3:0]       r_data;
  logic [AMT_W-1:0] r_rem;
  logic             r_carry;
  logic             r_ovf;

  logic [1:0]       w_k;
  logic [AMT_W-1:0] w_remNext;
  logic [3:0]       w_lost;
  logic             w_accept;

  // Per-pass shift amount and the bits this pass pushes out of the top.
  // The amount is capped at 3 because the stage cannot shift further.
  // Because w_k never exceeds r_rem, the remaining count cannot underflow.
  // The lost bits are data >> (4-k). When k is 0 this is a shift by 4,
  // which yields 0, so passes that shift nothing never flag an overflow.
  always_comb begin
    w_k = 2'd0;
    if (r_state == SHIFT) begin
      w_k = (r_rem >= AMT_W'(3)) ? 2'd3 : r_rem[1:0];
    end
    w_remNext = r_rem - AMT_W'(w_k);
    w_lost    = r_data >> (3'd4 - {1'b0, w_k});
  end

  // State register. Reset abandons any transaction in flight and no
  // response is ever produced for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake outputs.
  // A zero amount skips SHIFT entirely and goes straight to DONE.
  // req_ready is only raised in IDLE. The response handshake therefore
  // returns to IDLE first, so a new request cannot be taken in that cycle.
  always_comb begin
    w_nextState = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    busy        = 1'b1;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        busy      = 1'b0;
        req_ready = ~rst;
        w_accept  = req_valid & ~rst;
        if (w_accept) begin
          w_nextState = (req_amt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (w_remNext == '0) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath registers.
  // A request is captured on the accept edge. After that, each SHIFT cycle
  // replaces the partial result with the stage's output. The overflow flag
  // is computed from our own view of the lost bits, not from sh_carry.
  // sh_carry only reports a single bit, whereas a 3-bit shift can lose
  // up to three bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= 4'd0;
      r_rem   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_data  <= req_data;
      r_rem   <= req_amt;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == SHIFT) begin
      r_data  <= sh_out;
      r_rem   <= w_remNext;
      r_carry <= sh_carry;
      r_ovf   <= r_ovf | (|w_lost);
    end
  end

  assign sh_in     = r_data;
  assign sh_k      = w_k;
  assign rsp_data  = r_data;
  assign rsp_carry = r_carry;
  assign rsp_ovf   = r_ovf;

endmodule
